// File: rtl/vreg_file_burst.sv
// Vector register file with serial write bursts and dual-port serial read bursts.
// Optional same-edge write-to-read forwarding is enabled by defining VREG_BYPASS_EN.
module vreg_file_burst #(
  parameter int DW    = 16,
  parameter int VLEN  = 16,
  parameter int NREGS = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     WrStart,
  input  logic [$clog2(NREGS)-1:0] WrAddr,
  input  logic [DW-1:0]            DataIn_s,
  input  logic                     RdStart,
  input  logic [$clog2(NREGS)-1:0] RdAddrA,
  input  logic [$clog2(NREGS)-1:0] RdAddrB,
  output logic [DW-1:0]            DataOutA_s,
  output logic [DW-1:0]            DataOutB_s,
  output logic                     RdValid,
  output logic                     WrBusy,
  output logic                     RdBusy,
  output logic                     WrDone,
  output logic                     RdDone
);

  localparam int AW = $clog2(NREGS);
  localparam int EW = $clog2(VLEN);
  localparam logic [EW-1:0] LAST_EL = EW'(VLEN - 1);

  logic [DW-1:0] mem [NREGS*VLEN];

  logic [AW-1:0] wr_reg;
  logic [EW-1:0] wr_cnt;
  logic [AW-1:0] rd_reg_a;
  logic [AW-1:0] rd_reg_b;
  logic [EW-1:0] rd_cnt;

  logic          wr_accept;
  logic          rd_accept;
  logic          wr_en;
  logic [AW-1:0] wr_sel_reg;
  logic [EW-1:0] wr_sel_idx;
  logic [DW-1:0] rd_word_a;
  logic [DW-1:0] rd_word_b;

  // The accepting edge already writes element 0, so the target comes straight from the ports.
  always_comb begin
    wr_accept  = WrStart && !WrBusy;
    rd_accept  = RdStart && !RdBusy;
    wr_en      = Rst_n && (wr_accept || WrBusy);
    wr_sel_reg = WrBusy ? wr_reg : WrAddr;
    wr_sel_idx = WrBusy ? wr_cnt : '0;
  end

`ifdef VREG_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  always_comb begin
    fwd_a     = wr_en && (wr_sel_reg == rd_reg_a) && (wr_sel_idx == rd_cnt);
    fwd_b     = wr_en && (wr_sel_reg == rd_reg_b) && (wr_sel_idx == rd_cnt);
    rd_word_a = fwd_a ? DataIn_s : mem[{rd_reg_a, rd_cnt}];
    rd_word_b = fwd_b ? DataIn_s : mem[{rd_reg_b, rd_cnt}];
  end
`else
  always_comb begin
    rd_word_a = mem[{rd_reg_a, rd_cnt}];
    rd_word_b = mem[{rd_reg_b, rd_cnt}];
  end
`endif

  // Storage is deliberately left out of reset so a reset mid-burst keeps written elements.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[{wr_sel_reg, wr_sel_idx}] <= DataIn_s;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WrBusy <= 1'b0;
      WrDone <= 1'b0;
      wr_cnt <= '0;
      wr_reg <= '0;
    end else begin
      WrDone <= 1'b0;
      if (wr_accept) begin
        wr_reg <= WrAddr;
        wr_cnt <= EW'(1);
        WrBusy <= 1'b1;
      end else if (WrBusy) begin
        if (wr_cnt == LAST_EL) begin
          WrBusy <= 1'b0;
          wr_cnt <= '0;
          WrDone <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + EW'(1);
        end
      end
    end
  end

  // Read data is registered; outputs hold their last element while RdValid is low.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RdBusy     <= 1'b0;
      RdValid    <= 1'b0;
      RdDone     <= 1'b0;
      rd_cnt     <= '0;
      rd_reg_a   <= '0;
      rd_reg_b   <= '0;
      DataOutA_s <= '0;
      DataOutB_s <= '0;
    end else begin
      RdValid <= 1'b0;
      RdDone  <= 1'b0;
      if (rd_accept) begin
        rd_reg_a <= RdAddrA;
        rd_reg_b <= RdAddrB;
        rd_cnt   <= '0;
        RdBusy   <= 1'b1;
      end else if (RdBusy) begin
        DataOutA_s <= rd_word_a;
        DataOutB_s <= rd_word_b;
        RdValid    <= 1'b1;
        if (rd_cnt == LAST_EL) begin
          RdBusy <= 1'b0;
          rd_cnt <= '0;
          RdDone <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + EW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vreg_file_burst.sv
// Directed self-checking bench for vreg_file_burst (default parameters).
module tb_vreg_file_burst;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        WrStart;
  logic [2:0]  WrAddr;
  logic [15:0] DataIn_s;
  logic        RdStart;
  logic [2:0]  RdAddrA;
  logic [2:0]  RdAddrB;
  logic [15:0] DataOutA_s;
  logic [15:0] DataOutB_s;
  logic        RdValid;
  logic        WrBusy;
  logic        RdBusy;
  logic        WrDone;
  logic        RdDone;

  int errors = 0;
  int checks = 0;

  logic [15:0] got_a [16];
  logic [15:0] got_b [16];
  logic        got_d [16];
  logic        got_v [16];
  int          rd_lat;
  logic        post_valid;

  vreg_file_burst dut (
    .Clk        (clk),
    .Rst_n      (Rst_n),
    .WrStart    (WrStart),
    .WrAddr     (WrAddr),
    .DataIn_s   (DataIn_s),
    .RdStart    (RdStart),
    .RdAddrA    (RdAddrA),
    .RdAddrB    (RdAddrB),
    .DataOutA_s (DataOutA_s),
    .DataOutB_s (DataOutB_s),
    .RdValid    (RdValid),
    .WrBusy     (WrBusy),
    .RdBusy     (RdBusy),
    .WrDone     (WrDone),
    .RdDone     (RdDone)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [2:0] r, input logic [15:0] base, input logic [15:0] step);
    WrStart = 1'b1; WrAddr = r; DataIn_s = base;
    tick;
    WrStart = 1'b0;
    for (int i = 1; i < 16; i++) begin
      DataIn_s = base + step * 16'(i);
      tick;
    end
    tick;
  endtask

  task automatic read_burst(input logic [2:0] a, input logic [2:0] b);
    RdStart = 1'b1; RdAddrA = a; RdAddrB = b;
    tick;
    RdStart = 1'b0;
    rd_lat = 0;
    while (!RdValid && rd_lat < 8) begin
      tick;
      rd_lat++;
    end
    for (int i = 0; i < 16; i++) begin
      got_a[i] = DataOutA_s; got_b[i] = DataOutB_s;
      got_v[i] = RdValid;    got_d[i] = RdDone;
      tick;
    end
    post_valid = RdValid;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; WrStart = 1'b1; RdStart = 1'b1; WrAddr = 3'd1;
    RdAddrA = 3'd0; RdAddrB = 3'd0; DataIn_s = 16'h0;
    tick; tick;
    checks++; if (WrBusy !== 1'b0)      begin errors++; $display("FAIL rst_wrbusy got=%b exp=0", WrBusy); end
    checks++; if (RdBusy !== 1'b0)      begin errors++; $display("FAIL rst_rdbusy got=%b exp=0", RdBusy); end
    checks++; if (RdValid !== 1'b0)     begin errors++; $display("FAIL rst_rdvalid got=%b exp=0", RdValid); end
    checks++; if (WrDone !== 1'b0)      begin errors++; $display("FAIL rst_wrdone got=%b exp=0", WrDone); end
    checks++; if (RdDone !== 1'b0)      begin errors++; $display("FAIL rst_rddone got=%b exp=0", RdDone); end
    checks++; if (DataOutA_s !== 16'h0) begin errors++; $display("FAIL rst_douta got=%h exp=0000", DataOutA_s); end
    checks++; if (DataOutB_s !== 16'h0) begin errors++; $display("FAIL rst_doutb got=%h exp=0000", DataOutB_s); end
    WrStart = 1'b0;
    Rst_n = 1'b1;
    tick;
    RdStart = 1'b0;
    checks++; if (RdBusy !== 1'b1) begin errors++; $display("FAIL rst_first_start got=%b exp=1", RdBusy); end
    for (int i = 0; i < 18; i++) tick;
    checks++; if (RdBusy !== 1'b0) begin errors++; $display("FAIL rst_drain got=%b exp=0", RdBusy); end
  endtask

  task automatic test_write_read;
    WrStart = 1'b1; WrAddr = 3'd0; DataIn_s = 16'hA000;
    tick;
    WrStart = 1'b0;
    checks++; if (WrBusy !== 1'b1) begin errors++; $display("FAIL wr_busy_rise got=%b exp=1", WrBusy); end
    for (int i = 1; i < 16; i++) begin
      DataIn_s = 16'hA000 + 16'(i);
      if (i == 15) begin
        checks++; if (WrDone !== 1'b0) begin errors++; $display("FAIL wr_done_early got=%b exp=0", WrDone); end
      end
      tick;
    end
    checks++; if (WrBusy !== 1'b0) begin errors++; $display("FAIL wr_busy_fall got=%b exp=0", WrBusy); end
    checks++; if (WrDone !== 1'b1) begin errors++; $display("FAIL wr_done_pulse got=%b exp=1", WrDone); end
    tick;
    checks++; if (WrDone !== 1'b0) begin errors++; $display("FAIL wr_done_width got=%b exp=0", WrDone); end
    read_burst(3'd0, 3'd0);
    checks++; if (rd_lat !== 1) begin errors++; $display("FAIL rd_latency got=%0d exp=1", rd_lat); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_v[i] !== 1'b1) begin errors++; $display("FAIL rw_valid[%0d] got=%b exp=1", i, got_v[i]); end
      checks++; if (got_a[i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL rw_a[%0d] got=%h exp=%h", i, got_a[i], 16'hA000 + 16'(i)); end
      checks++; if (got_b[i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL rw_b[%0d] got=%h exp=%h", i, got_b[i], 16'hA000 + 16'(i)); end
      checks++; if (got_d[i] !== (i == 15)) begin errors++; $display("FAIL rw_done[%0d] got=%b exp=%b", i, got_d[i], (i == 15)); end
    end
    checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_end got=%b exp=0", post_valid); end
    tick;
    checks++; if (DataOutA_s !== 16'hA00F) begin errors++; $display("FAIL rw_hold got=%h exp=a00f", DataOutA_s); end
  endtask

  task automatic test_two_regs;
    write_burst(3'd2, 16'h0200, 16'd1);
    write_burst(3'd5, 16'h0500, 16'd1);
    read_burst(3'd2, 3'd5);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_a[i] !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL two_a[%0d] got=%h exp=%h", i, got_a[i], 16'h0200 + 16'(i)); end
      checks++; if (got_b[i] !== 16'h0500 + 16'(i)) begin errors++; $display("FAIL two_b[%0d] got=%h exp=%h", i, got_b[i], 16'h0500 + 16'(i)); end
    end
  endtask

  task automatic test_collision;
    logic [15:0] exp;
    RdStart = 1'b1; RdAddrA = 3'd3; RdAddrB = 3'd3;
    tick;
    RdStart = 1'b0;
    WrStart = 1'b1; WrAddr = 3'd3; DataIn_s = 16'h3300;
    tick;
    WrStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got_a[i] = DataOutA_s; got_v[i] = RdValid;
      DataIn_s = 16'h3300 + 16'(i + 1);
      tick;
    end
    for (int i = 0; i < 16; i++) begin
`ifdef VREG_BYPASS_EN
      exp = 16'h3300 + 16'(i);
`else
      exp = 16'h1111;
`endif
      checks++; if (got_v[i] !== 1'b1) begin errors++; $display("FAIL coll_valid[%0d] got=%b exp=1", i, got_v[i]); end
      checks++; if (got_a[i] !== exp) begin errors++; $display("FAIL coll_a[%0d] got=%h exp=%h", i, got_a[i], exp); end
    end
    read_burst(3'd3, 3'd3);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_b[i] !== 16'h3300 + 16'(i)) begin errors++; $display("FAIL coll_after[%0d] got=%h exp=%h", i, got_b[i], 16'h3300 + 16'(i)); end
    end
  endtask

  task automatic test_ignored_start;
    int dones;
    dones = 0;
    WrStart = 1'b1; WrAddr = 3'd3; DataIn_s = 16'h3400;
    tick;
    for (int i = 1; i < 16; i++) begin
      WrStart = (i == 5);
      WrAddr = (i == 5) ? 3'd6 : 3'd3;
      DataIn_s = 16'h3400 + 16'(i);
      tick;
      if (WrDone === 1'b1) dones++;
    end
    WrStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (WrDone === 1'b1) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_wrdone_count got=%0d exp=1", dones); end
    checks++; if (WrBusy !== 1'b0) begin errors++; $display("FAIL ign_wrbusy got=%b exp=0", WrBusy); end
    read_burst(3'd3, 3'd6);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_a[i] !== 16'h3400 + 16'(i)) begin errors++; $display("FAIL ign_r3[%0d] got=%h exp=%h", i, got_a[i], 16'h3400 + 16'(i)); end
      checks++; if (got_b[i] !== 16'h6600 + 16'(i)) begin errors++; $display("FAIL ign_r6[%0d] got=%h exp=%h", i, got_b[i], 16'h6600 + 16'(i)); end
    end
  endtask

  task automatic test_reset_midburst;
    logic [15:0] exp;
    RdStart = 1'b1; RdAddrA = 3'd0; RdAddrB = 3'd0;
    tick;
    RdStart = 1'b0;
    WrStart = 1'b1; WrAddr = 3'd1; DataIn_s = 16'hB000;
    tick;
    WrStart = 1'b0;
    for (int i = 1; i < 8; i++) begin
      DataIn_s = 16'hB000 + 16'(i);
      tick;
    end
    DataIn_s = 16'hB008;
    Rst_n = 1'b0;
    #1;
    checks++; if (WrBusy !== 1'b0)      begin errors++; $display("FAIL mid_wrbusy got=%b exp=0", WrBusy); end
    checks++; if (RdBusy !== 1'b0)      begin errors++; $display("FAIL mid_rdbusy got=%b exp=0", RdBusy); end
    checks++; if (RdValid !== 1'b0)     begin errors++; $display("FAIL mid_rdvalid got=%b exp=0", RdValid); end
    checks++; if (DataOutA_s !== 16'h0) begin errors++; $display("FAIL mid_douta got=%h exp=0000", DataOutA_s); end
    checks++; if (DataOutB_s !== 16'h0) begin errors++; $display("FAIL mid_doutb got=%h exp=0000", DataOutB_s); end
    tick; tick;
    Rst_n = 1'b1;
    tick;
    checks++; if (WrBusy !== 1'b0) begin errors++; $display("FAIL mid_no_resume got=%b exp=0", WrBusy); end
    read_burst(3'd1, 3'd1);
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? 16'hB000 + 16'(i) : 16'h0000;
      checks++; if (got_a[i] !== exp) begin errors++; $display("FAIL mid_r1[%0d] got=%h exp=%h", i, got_a[i], exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int gap;
    int seen;
    bit sent;
    logic [15:0] ea;
    logic [15:0] eb;
    gap = 0; seen = 0; sent = 0;
    RdStart = 1'b1; RdAddrA = 3'd0; RdAddrB = 3'd7;
    tick;
    RdStart = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (RdValid === 1'b1) begin
        qa.push_back(DataOutA_s); qb.push_back(DataOutB_s);
        seen++;
      end else if (seen > 0 && seen < 32) begin
        gap++;
      end
      if (!sent && RdBusy === 1'b0) begin
        RdStart = 1'b1; RdAddrA = 3'd7; RdAddrB = 3'd0; sent = 1;
      end else begin
        RdStart = 1'b0;
      end
    end
    checks++; if (gap !== 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=1", gap); end
    checks++; if (qa.size() !== 32) begin errors++; $display("FAIL b2b_count got=%0d exp=32", qa.size()); end
    if (qa.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        ea = (i < 16) ? 16'hA000 + 16'(i) : 16'h7700 + 16'(i - 16);
        eb = (i < 16) ? 16'h7700 + 16'(i) : 16'hA000 + 16'(i - 16);
        checks++; if (qa[i] !== ea) begin errors++; $display("FAIL b2b_a[%0d] got=%h exp=%h", i, qa[i], ea); end
        checks++; if (qb[i] !== eb) begin errors++; $display("FAIL b2b_b[%0d] got=%h exp=%h", i, qb[i], eb); end
      end
    end
  endtask

  initial begin
    test_reset;
    write_burst(3'd1, 16'h0000, 16'd0);
    write_burst(3'd3, 16'h1111, 16'd0);
    write_burst(3'd6, 16'h6600, 16'd1);
    write_burst(3'd7, 16'h7700, 16'd1);
    test_write_read;
    test_two_regs;
    test_collision;
    test_ignored_start;
    test_reset_midburst;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
